// File: rtl/rca_seq_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Holds the FSM state encoding, nibble width and index-width helper.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Width of a counter that indexes n items; never narrower than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rca_nib_slice.sv
// Combinational 4-bit ripple-carry slice: a full-adder chain with carry-in.
// Zero latency; no flow control.
module rca_nib_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic       co,
    output logic [3:0] sum
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/rca_nibble_seq_ctrl.sv
// Nibble-serial adder: one 4-bit slice reused LSB-first, carry held in a register between nibbles.
// Latency: result valid WIDTH/4 cycles after accept; optional ovf output via RCA_SEQ_OVF_FLAG_EN.
// Backpressure: no new accept until the result is taken; s/cout held while out_ready is low.
module rca_nibble_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef RCA_SEQ_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int IDX_W = clog2(NNIB);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NNIB - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic [NIB_W-1:0]  sl_x;
    logic [NIB_W-1:0]  sl_y;
    logic [NIB_W-1:0]  sl_sum;
    logic              sl_co;

    assign sl_x = a_reg[idx*NIB_W +: NIB_W];
    assign sl_y = b_reg[idx*NIB_W +: NIB_W];

    rca_nib_slice u_slice (
        .x   (sl_x),
        .y   (sl_y),
        .ci  (carry),
        .co  (sl_co),
        .sum (sl_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Upper nibbles of s keep stale data until overwritten; only the DONE value matters.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef RCA_SEQ_OVF_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    s[idx*NIB_W +: NIB_W] <= sl_sum;
                    carry                 <= sl_co;
                    idx                   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout <= sl_co;
`ifdef RCA_SEQ_OVF_FLAG_EN
                        ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (sl_sum[NIB_W-1] != a_reg[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_nibble_seq_ctrl.sv
// Directed plus randomized bench for rca_nibble_seq_ctrl (WIDTH=16); ovf checked when RCA_SEQ_OVF_FLAG_EN is defined.
module tb_rca_nibble_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        busy;
`ifdef RCA_SEQ_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks;
    int failures;

    rca_nibble_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
`ifdef RCA_SEQ_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction from IDLE: accept, wait for result, hold, handshake.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input int hold);
        logic [16:0] full;
        logic [15:0] s_seen;
        logic        c_seen;
        int          n;
        full = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 32'd4);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("sum", {16'd0, s}, {16'd0, full[15:0]});
        chk("cout", {31'd0, cout}, {31'd0, full[16]});
`ifdef RCA_SEQ_OVF_FLAG_EN
        chk("ovf", {31'd0, ovf}, {31'd0, (ta[15] == tb_[15]) && (full[15] != ta[15])});
`endif
        s_seen = s;
        c_seen = cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_sum", {16'd0, s}, {16'd0, s_seen});
            chk("hold_cout", {31'd0, cout}, {31'd0, c_seen});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drop_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, s}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 0);
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 5);

        // Abort during the second RUN cycle.
        a = 16'h8888; b = 16'h8888; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", {16'd0, s}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        run_op(16'h8888, 16'h8888, 1'b0, 1);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'hFFFF, 1'b0, 0);

        for (int k = 0; k < 24; k++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
